// File: rtl/scic_pkg.sv
// Shared SCIC definitions: loader states, default IO addresses and CPU opcodes.
package scic_pkg;

    typedef enum logic [1:0] {
        StHold,
        StRun,
        StLoad
    } loader_state_e;

    localparam logic [15:0] GpioAddrDefault  = 16'hFFFF;
    localparam logic [15:0] CycleAddrDefault = 16'hFFFE;

    localparam logic [3:0] OpStore = 4'b0111;

endpackage

// File: rtl/scic_load_assembler.sv
// Packs big-endian program bytes into 32-bit words and emits one RAM write per word.
module scic_load_assembler #(
    parameter int unsigned DepthLog2 = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 accept_i,
    input  logic [7:0]           byte_i,
    input  logic                 last_i,
    output logic                 wr_en_o,
    output logic [DepthLog2-1:0] wr_addr_o,
    output logic [31:0]          wr_data_o
);

    logic [1:0]           count_q, count_d;
    logic [23:0]          shift_q, shift_d;
    logic [DepthLog2-1:0] addr_q, addr_d;
    logic [31:0]          new_word;
    logic [4:0]           pad_shift;

    always_comb begin
        count_d   = count_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        wr_en_o   = 1'b0;
        new_word  = {shift_q, byte_i};
        // Left-align a short final word so the unfilled low bytes become zero.
        pad_shift = {2'd3 - count_q, 3'b000};
        wr_data_o = new_word << pad_shift;
        wr_addr_o = addr_q;

        if (clear_i) begin
            count_d = '0;
            shift_d = '0;
            addr_d  = '0;
        end else if (accept_i) begin
            if (count_q == 2'd3 || last_i) begin
                wr_en_o = 1'b1;
                count_d = '0;
                shift_d = '0;
                addr_d  = addr_q + 1'b1;
            end else begin
                count_d = count_q + 2'd1;
                shift_d = new_word[23:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            shift_q <= '0;
            addr_q  <= '0;
        end else begin
            count_q <= count_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: rtl/scic_memory_responder.sv
// SCIC memory side: word RAM, GPIO register, cycle counter and a byte-serial
// program loader that holds the CPU in reset while it fills RAM.
module scic_memory_responder
    import scic_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [15:0] GPIO_ADDR  = GpioAddrDefault,
    parameter logic [15:0] CYCLE_ADDR = CycleAddrDefault
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [31:0] cpu_rdata,
    output logic        cpu_reset,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_busy,
    output logic [31:0] gpio_out
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    logic [31:0] mem [Depth];

    loader_state_e state_q, state_d;
    logic [31:0]   gpio_q, gpio_d;
    logic [31:0]   cycle_q, cycle_d;

    logic                  asm_clear, asm_accept, asm_we;
    logic [DEPTH_LOG2-1:0] asm_addr;
    logic [31:0]           asm_data;

    logic                  in_range;
    logic [DEPTH_LOG2-1:0] cpu_index;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [31:0]           mem_wdata;

    assign in_range  = ({16'b0, cpu_address} < (32'd1 << DEPTH_LOG2));
    assign cpu_index = cpu_address[DEPTH_LOG2-1:0];
    assign gpio_out  = gpio_q;

    scic_load_assembler #(
        .DepthLog2(DEPTH_LOG2)
    ) u_assembler (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (asm_clear),
        .accept_i (asm_accept),
        .byte_i   (load_byte),
        .last_i   (load_last),
        .wr_en_o  (asm_we),
        .wr_addr_o(asm_addr),
        .wr_data_o(asm_data)
    );

    always_comb begin
        state_d    = state_q;
        cpu_reset  = 1'b1;
        load_ready = 1'b0;
        load_busy  = 1'b0;
        asm_clear  = 1'b0;
        asm_accept = 1'b0;
        unique case (state_q)
            StHold: state_d = StRun;
            StRun: begin
                cpu_reset = 1'b0;
                if (load_start) begin
                    state_d   = StLoad;
                    asm_clear = 1'b1;
                end
            end
            StLoad: begin
                load_ready = 1'b1;
                load_busy  = 1'b1;
                // A restart takes precedence over a byte offered in the same cycle.
                if (load_start) begin
                    asm_clear = 1'b1;
                end else if (load_valid) begin
                    asm_accept = 1'b1;
                    if (load_last) begin
                        state_d = StHold;
                    end
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_comb begin
        gpio_d    = gpio_q;
        cycle_d   = cycle_q + 32'd1;
        mem_we    = 1'b0;
        mem_waddr = asm_addr;
        mem_wdata = asm_data;
        if (asm_we) begin
            mem_we = 1'b1;
        end else if (cpu_we && !cpu_reset) begin
            if (cpu_address == GPIO_ADDR) begin
                gpio_d = cpu_wdata;
            end else if (cpu_address != CYCLE_ADDR && in_range) begin
                mem_we    = 1'b1;
                mem_waddr = cpu_index;
                mem_wdata = cpu_wdata;
            end
        end
    end

    always_comb begin
        if (cpu_address == GPIO_ADDR) begin
            cpu_rdata = gpio_q;
        end else if (cpu_address == CYCLE_ADDR) begin
            cpu_rdata = cycle_q;
        end else if (in_range) begin
            cpu_rdata = mem[cpu_index];
        end else begin
            cpu_rdata = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StHold;
            gpio_q  <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            gpio_q  <= gpio_d;
            cycle_q <= cycle_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule
